// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction/PC widths, the NOP encoding and the
// prefetch queue entry layout.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h1000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} entries; flush wins over push.
// The head entry is only meaningful while count_o is non-zero.
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  pf_entry_t     wdata_i,
    output logic [CW-1:0] count_o,
    output pf_entry_t     head_o
);

    pf_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/inst_prefetch_q.sv
// Instruction prefetch queue: issues sequential word fetches under a credit
// limit, tags returns with their PC and hands them to decode one per cycle.
module inst_prefetch_q
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [15:0] inst_pcplus1,
    input  logic        inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshakes: a fetch transfers when imem_req && imem_ready; decode takes
    // the head when inst_valid && inst_ready. Neither valid waits on its ready.
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic            fire;
    logic            rsp_keep;
    logic            rsp_drop;
    logic            pop;
    pf_entry_t       wr_entry;
    pf_entry_t       head;

    assign credit   = {1'b0, count} + {1'b0, outstanding_q} - {1'b0, drop_q};
    assign imem_req = !rst && !halt && !redirect && (credit < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign fire     = imem_req && imem_ready;

    assign rsp_keep = imem_rvalid && (drop_q == '0);
    assign rsp_drop = imem_rvalid && (drop_q != '0);

    // Once drop is zero every in-flight request is post-redirect and sequential,
    // so the oldest one sits exactly 'outstanding' words behind fetch_pc.
    assign wr_entry.pc    = fetch_pc_q - PC_W'(outstanding_q);
    assign wr_entry.instr = imem_rdata;

    assign pop = inst_valid && inst_ready && !redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            outstanding_d = outstanding_q - CW'(imem_rvalid);
            drop_d        = outstanding_q - CW'(imem_rvalid);
        end else begin
            if (fire) fetch_pc_d = fetch_pc_q + 16'd1;
            outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rvalid);
            if (rsp_drop) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_keep),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i (wr_entry),
        .count_o (count),
        .head_o  (head)
    );

    assign inst_valid   = (count != '0);
    assign inst         = inst_valid ? head.instr : NOP_INSTR;
    assign inst_pc      = inst_valid ? head.pc : '0;
    assign inst_pcplus1 = inst_pc + 16'd1;

    rsp_without_req_a: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (outstanding_q == '0)));

endmodule

// File: tb/tb_inst_prefetch_q.sv
// Directed bench for inst_prefetch_q with an in-order fixed-latency memory model.
module tb_inst_prefetch_q;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        inst_ready;

  logic        imem_req, w_req;
  logic [15:0] imem_addr, w_addr;
  logic        inst_valid, w_valid;
  logic [15:0] inst, w_inst;
  logic [15:0] inst_pc, w_inst_pc;
  logic [15:0] inst_pcplus1, w_pcplus1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int req_cnt = 0;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } mreq_t;
  mreq_t mq[$];

  inst_prefetch_q #(.DEPTH(4), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pcplus1(inst_pcplus1),
    .inst_ready(inst_ready)
  );

  // Same stimulus and response timing; its addresses sit 16'hFFFE above u_dut's.
  inst_prefetch_q #(.DEPTH(4), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_inst_pc), .inst_pcplus1(w_pcplus1),
    .inst_ready(inst_ready)
  );

  function automatic logic [15:0] mk(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory model: capture accepted requests mid-cycle, answer 'lat' cycles later
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
    end else if (imem_req && imem_ready) begin
      mq.push_back('{due: cyc + lat, addr: imem_addr});
      req_cnt++;
    end
  end

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 16'hDEAD;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (!rst && mq.size() > 0 && mq[0].due == cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mk(mq[0].addr);
        mq.delete(0);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 16'hDEAD;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l, input logic ir);
    rst = 1'b1;
    halt = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    imem_ready = 1'b1;
    inst_ready = ir;
    lat = l;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    step(); #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
    checks++; if (inst !== 16'h1000) begin failures++; $display("FAIL rst_inst got=%h exp=1000", inst); end
    checks++; if (inst_pc !== 16'h0000) begin failures++; $display("FAIL rst_pc got=%h exp=0000", inst_pc); end
    checks++; if (inst_pcplus1 !== 16'h0001) begin failures++; $display("FAIL rst_pcp1 got=%h exp=0001", inst_pcplus1); end
    step(); step();
    rst = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      failures++; $display("FAIL first_req got=%b/%h exp=1/0000", imem_req, imem_addr); end
    repeat (3) step();
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0001) begin
      failures++; $display("FAIL pre_async got=%b/%h exp=1/0001", inst_valid, inst_pc); end
    rst = 1'b1; #1;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || inst !== 16'h1000) begin
      failures++; $display("FAIL async_rst got=%b/%b/%h exp=0/0/1000", inst_valid, imem_req, inst); end
  endtask

  task automatic test_stream();
    do_reset(1, 1'b1);
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      failures++; $display("FAIL stream_c0 got=%b/%h exp=1/0000", imem_req, imem_addr); end
    for (int i = 1; i <= 8; i++) begin
      step(); #1;
      checks++; if (imem_addr !== 16'(i)) begin
        failures++; $display("FAIL stream_addr got=%h exp=%h", imem_addr, 16'(i)); end
      if (i < 2) begin
        checks++; if (inst_valid !== 1'b0) begin
          failures++; $display("FAIL stream_early_valid got=%b exp=0", inst_valid); end
      end else begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'(i - 2) || inst !== mk(16'(i - 2))
                      || inst_pcplus1 !== 16'(i - 1)) begin
          failures++; $display("FAIL stream_inst got=%b/%h/%h/%h exp=1/%h/%h/%h", inst_valid, inst_pc,
                               inst, inst_pcplus1, 16'(i - 2), mk(16'(i - 2)), 16'(i - 1)); end
      end
    end
  endtask

  task automatic test_back_pressure();
    int base;
    int exp_pc;
    do_reset(2, 1'b0);
    base = req_cnt;
    repeat (6) step();
    #1;
    checks++; if (req_cnt - base != 4) begin
      failures++; $display("FAIL bp_req_count got=%0d exp=4", req_cnt - base); end
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 16'h0000) begin
      failures++; $display("FAIL bp_full got=%b/%b/%h exp=0/1/0000", imem_req, inst_valid, inst_pc); end
    step();
    inst_ready = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin
      failures++; $display("FAIL bp_still_full got=%b exp=0", imem_req); end
    exp_pc = 0;
    for (int k = 0; k < 24; k++) begin
      if (inst_valid) begin
        checks++; if (inst_pc !== 16'(exp_pc) || inst !== mk(16'(exp_pc))) begin
          failures++; $display("FAIL bp_order got=%h/%h exp=%h/%h", inst_pc, inst,
                               16'(exp_pc), mk(16'(exp_pc))); end
        exp_pc++;
      end
      step(); #1;
    end
    checks++; if (exp_pc != 24) begin
      failures++; $display("FAIL bp_delivered got=%0d exp=24", exp_pc); end
  endtask

  task automatic test_redirect_outstanding();
    do_reset(3, 1'b1);
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 16'h0040; #1;
    checks++; if (imem_req !== 1'b0) begin
      failures++; $display("FAIL redir_req got=%b exp=0", imem_req); end
    step();
    redirect = 1'b0; #1;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      failures++; $display("FAIL redir_next got=%b/%b/%h exp=0/1/0040", inst_valid, imem_req, imem_addr); end
    for (int k = 5; k <= 11; k++) begin
      step(); #1;
      if (k < 8) begin
        checks++; if (inst_valid !== 1'b0) begin
          failures++; $display("FAIL redir_drop got=%b/%h exp=0", inst_valid, inst_pc); end
      end else begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'(16'h0040 + k - 8)
                      || inst !== mk(16'(16'h0040 + k - 8))) begin
          failures++; $display("FAIL redir_deliver got=%b/%h/%h exp=1/%h", inst_valid, inst_pc, inst,
                               16'(16'h0040 + k - 8)); end
      end
    end
  endtask

  task automatic test_redirect_coincident();
    do_reset(2, 1'b1);
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 16'h0100; #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0000 || imem_rvalid !== 1'b1) begin
      failures++; $display("FAIL coin_setup got=%b/%h/%b exp=1/0000/1", inst_valid, inst_pc, imem_rvalid); end
    step();
    redirect = 1'b0; halt = 1'b1; #1;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL coin_flush got=%b/%b exp=0/0", inst_valid, imem_req); end
    checks++; if (u_dut.drop_q !== 3'd1 || u_dut.outstanding_q !== 3'd1) begin
      failures++; $display("FAIL coin_drop got=%0d/%0d exp=1/1", u_dut.drop_q, u_dut.outstanding_q); end
    step(); #1;
    checks++; if (u_dut.outstanding_q !== 3'd0 || u_dut.drop_q !== 3'd0 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL coin_drained got=%0d/%0d/%b exp=0/0/0", u_dut.outstanding_q,
                           u_dut.drop_q, inst_valid); end
    halt = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
      failures++; $display("FAIL coin_resume got=%b/%h exp=1/0100", imem_req, imem_addr); end
    step(); step(); #1;
    checks++; if (inst_valid !== 1'b0) begin
      failures++; $display("FAIL coin_gap got=%b exp=0", inst_valid); end
    step(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0100 || inst !== mk(16'h0100)) begin
      failures++; $display("FAIL coin_first got=%b/%h/%h exp=1/0100/%h", inst_valid, inst_pc, inst,
                           mk(16'h0100)); end
  endtask

  task automatic test_halt();
    do_reset(3, 1'b1);
    step(); step();
    halt = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin
      failures++; $display("FAIL halt_req got=%b exp=0", imem_req); end
    for (int k = 3; k <= 8; k++) begin
      step(); #1;
      checks++; if (imem_req !== 1'b0) begin
        failures++; $display("FAIL halt_hold got=%b exp=0", imem_req); end
      if (k == 4 || k == 5) begin
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'(k - 4) || inst !== mk(16'(k - 4))) begin
          failures++; $display("FAIL halt_land got=%b/%h/%h exp=1/%h", inst_valid, inst_pc, inst,
                               16'(k - 4)); end
      end else begin
        checks++; if (inst_valid !== 1'b0 || inst !== 16'h1000) begin
          failures++; $display("FAIL halt_empty got=%b/%h exp=0/1000", inst_valid, inst); end
      end
    end
    checks++; if (u_dut.outstanding_q !== 3'd0) begin
      failures++; $display("FAIL halt_outstanding got=%0d exp=0", u_dut.outstanding_q); end
    step();
    halt = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      failures++; $display("FAIL halt_resume got=%b/%h exp=1/0002", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset(1, 1'b1);
    #1;
    checks++; if (w_req !== 1'b1 || w_addr !== 16'hFFFE) begin
      failures++; $display("FAIL wrap_a0 got=%b/%h exp=1/fffe", w_req, w_addr); end
    step(); #1;
    checks++; if (w_addr !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_a1 got=%h exp=ffff", w_addr); end
    step(); #1;
    checks++; if (w_addr !== 16'h0000 || w_inst_pc !== 16'hFFFE || w_pcplus1 !== 16'hFFFF
                  || w_inst !== mk(16'h0000)) begin
      failures++; $display("FAIL wrap_c2 got=%h/%h/%h/%h exp=0000/fffe/ffff/%h", w_addr, w_inst_pc,
                           w_pcplus1, w_inst, mk(16'h0000)); end
    step(); #1;
    checks++; if (w_valid !== 1'b1 || w_inst_pc !== 16'hFFFF || w_pcplus1 !== 16'h0000) begin
      failures++; $display("FAIL wrap_pcp1 got=%b/%h/%h exp=1/ffff/0000", w_valid, w_inst_pc, w_pcplus1); end
    step(); #1;
    checks++; if (w_inst_pc !== 16'h0000 || w_pcplus1 !== 16'h0001 || w_inst !== mk(16'h0002)) begin
      failures++; $display("FAIL wrap_zero got=%h/%h/%h exp=0000/0001/%h", w_inst_pc, w_pcplus1, w_inst,
                           mk(16'h0002)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_redirect_outstanding();
    test_redirect_coincident();
    test_halt();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
